mem_arbiter: RTL and testbench

Two-master arbiter that shares the single unified instruction/data memory between the multicycle MIPS core (master 0) and a loader/DMA engine (master 1). It sits between the requesters and the `mem` block and uses a req/gnt/ack handshake. The arbiter sequences ownership with a small FSM, round-robin tie-breaking and a bounded locked-burst counter. Memory read is asynchronous and write is synchronous, so each granted access completes in one cycle.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_lock;
  logic        m1_lock;
  logic        m0_we;
  logic        m1_we;
  logic [31:0] m0_adr;
  logic [31:0] m1_adr;
  logic [31:0] m0_wd;
  logic [31:0] m1_wd;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] m0_rd;
  logic [31:0] m1_rd;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    input  m0_adr, m1_adr, m0_wd, m1_wd, mem_rd,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rd, m1_rd,
    output mem_we, mem_adr, mem_wd
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
    output m0_adr, m1_adr, m0_wd, m1_wd, mem_rd,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rd, m1_rd,
    input  mem_we, mem_adr, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified instruction/data memory: round-robin ties,
// parking on the last owner and a bounded locked burst under contention.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] beats;
  logic [BW-1:0] beats_sat;
  logic          under_limit;
  logic          ack0;
  logic          ack1;
  logic          mux_we;
  logic [31:0]   mux_adr;
  logic [31:0]   mux_wd;

  assign ack0 = (state == GRANT0) & bus.m0_req;
  assign ack1 = (state == GRANT1) & bus.m1_req;

  assign bus.m0_gnt = (state == GRANT0);
  assign bus.m1_gnt = (state == GRANT1);
  assign bus.m0_ack = ack0;
  assign bus.m1_ack = ack1;
  assign bus.m0_rd  = bus.mem_rd;
  assign bus.m1_rd  = bus.mem_rd;

  // A locked owner may keep the bus only while this beat is not its last allowed one.
  assign under_limit = ({1'b0, beats} + (BW+1)'(1)) < {1'b0, BEATS_MAX};
  assign beats_sat   = (beats == BEATS_MAX) ? beats : beats + 1'b1;

  always_comb begin
    mux_we  = 1'b0;
    mux_adr = '0;
    mux_wd  = '0;
    case (state)
      GRANT0: begin
        mux_we  = ack0 & bus.m0_we;
        mux_adr = bus.m0_adr;
        mux_wd  = bus.m0_wd;
      end
      GRANT1: begin
        mux_we  = ack1 & bus.m1_we;
        mux_adr = bus.m1_adr;
        mux_wd  = bus.m1_wd;
      end
      default: ;
    endcase
  end

  assign bus.mem_we  = mux_we;
  assign bus.mem_adr = mux_adr;
  assign bus.mem_wd  = mux_wd;

  // Reset leaves last=1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req && (!bus.m1_req || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
            beats <= '0;
          end else if (bus.m1_req) begin
            state <= GRANT1;
            last  <= 1'b1;
            beats <= '0;
          end
        end
        GRANT0: begin
          if (!bus.m0_req) begin
            if (bus.m1_req) begin
              state <= GRANT1;
              last  <= 1'b1;
              beats <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (!bus.m1_req || (bus.m0_lock && under_limit)) begin
            beats <= beats_sat;
          end else begin
            state <= GRANT1;
            last  <= 1'b1;
            beats <= '0;
          end
        end
        GRANT1: begin
          if (!bus.m1_req) begin
            if (bus.m0_req) begin
              state <= GRANT0;
              last  <= 1'b0;
              beats <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (!bus.m0_req || (bus.m1_lock && under_limit)) begin
            beats <= beats_sat;
          end else begin
            state <= GRANT0;
            last  <= 1'b0;
            beats <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// compared against an ownership/scoreboard model of the shared memory.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int RAND_CYCLES = 3000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic        req  [2];
  logic        lock [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  logic [31:0] wd   [2];

  assign bus.m0_req  = req[0];
  assign bus.m1_req  = req[1];
  assign bus.m0_lock = lock[0];
  assign bus.m1_lock = lock[1];
  assign bus.m0_we   = we[0];
  assign bus.m1_we   = we[1];
  assign bus.m0_adr  = adr[0];
  assign bus.m1_adr  = adr[1];
  assign bus.m0_wd   = wd[0];
  assign bus.m1_wd   = wd[1];

  // Memory with asynchronous read and synchronous write; preload port for setup.
  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  assign bus.mem_rd = mem[bus.mem_adr[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.mem_we) mem[bus.mem_adr[7:2]] <= bus.mem_wd;
  end

  // Reference model: who owns the bus, who owned it last, beats in this tenure.
  int          owner;
  int          last;
  int          run;
  int          wait_cnt [2];
  logic [31:0] ref_mem  [64];
  logic        exp_ack  [2];
  logic        exp_we;
  logic [31:0] exp_adr;
  logic [31:0] exp_wd;
  logic        pending  [2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int next_owner();
    int o;
    if (owner < 0) begin
      if (req[0] && req[1]) return 1 - last;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
    end
    o = 1 - owner;
    if (!req[owner]) return req[o] ? o : -1;
    if (!req[o]) return owner;
    if (lock[owner] && (run + 1 < MAX_BURST)) return owner;
    return o;
  endfunction

  task automatic sample();
    logic        obs_gnt [2];
    logic        obs_ack [2];
    logic [31:0] obs_rd  [2];
    @(negedge clk);
    obs_gnt[0] = bus.m0_gnt;
    obs_gnt[1] = bus.m1_gnt;
    obs_ack[0] = bus.m0_ack;
    obs_ack[1] = bus.m1_ack;
    obs_rd[0]  = bus.m0_rd;
    obs_rd[1]  = bus.m1_rd;
    exp_we  = 1'b0;
    exp_adr = '0;
    exp_wd  = '0;
    if (owner >= 0) begin
      exp_we  = req[owner] && we[owner];
      exp_adr = adr[owner];
      exp_wd  = wd[owner];
    end
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = (owner == i) && req[i];
      check($sformatf("gnt%0d", i), {31'b0, obs_gnt[i]}, {31'b0, owner == i});
      check($sformatf("ack%0d", i), {31'b0, obs_ack[i]}, {31'b0, exp_ack[i]});
      if (exp_ack[i] && !we[i])
        check($sformatf("rd%0d", i), obs_rd[i], ref_mem[adr[i][7:2]]);
      if (exp_ack[i]) begin
        checks++;
        assert (wait_cnt[i] <= MAX_BURST + 1) else begin
          errors++;
          $error("FAIL wait%0d: observed %0d cycles required <= %0d", i, wait_cnt[i], MAX_BURST + 1);
        end
      end
    end
    check("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we});
    check("mem_adr", bus.mem_adr, exp_adr);
    check("mem_wd", bus.mem_wd, exp_wd);
  endtask

  task automatic advance();
    int nxt;
    nxt = next_owner();
    @(posedge clk);
    if (exp_we) ref_mem[exp_adr[7:2]] = exp_wd;
    for (int i = 0; i < 2; i++)
      wait_cnt[i] = (req[i] && !exp_ack[i]) ? wait_cnt[i] + 1 : 0;
    if (!reset) begin
      owner = -1;
      last  = 1;
      run   = 0;
    end else begin
      if (nxt >= 0 && nxt == owner) begin
        if (run < MAX_BURST) run++;
      end else if (nxt >= 0) begin
        run  = 0;
        last = nxt;
      end
      owner = nxt;
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (pending[i] && exp_ack[i]) pending[i] = 1'b0;
      if (pending[i] && $urandom_range(0, 19) == 0) begin
        pending[i] = 1'b0;
      end else if (!pending[i] && $urandom_range(0, 9) < 6) begin
        pending[i] = 1'b1;
        we[i]  = 1'($urandom_range(0, 1));
        adr[i] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        wd[i]  = $urandom;
      end
      req[i]  = pending[i];
      lock[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lock[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wd[i] = '0;
      pending[i] = 1'b0; exp_ack[i] = 1'b0; wait_cnt[i] = 0;
    end
    pre_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_idx    = 6'(i);
      pre_val    = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pre_val;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    owner = -1;
    last  = 1;
    run   = 0;

    // Reset held with both masters requesting
    req[0] = 1'b1; req[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("rst_gnt0", {31'b0, bus.m0_gnt}, 32'd0);
      check("rst_gnt1", {31'b0, bus.m1_gnt}, 32'd0);
      check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      advance();
    end
    reset = 1'b1;
    cycle();
    sample();
    check("tie_gnt0", {31'b0, bus.m0_gnt}, 32'd1);
    advance();
    req[0] = 1'b0; req[1] = 1'b0;
    cycle();

    // Single read by master 1
    req[1] = 1'b1; adr[1] = 32'h10; we[1] = 1'b0;
    cycle();
    sample();
    check("read_gnt1", {31'b0, bus.m1_gnt}, 32'd1);
    check("read_ack1", {31'b0, bus.m1_ack}, 32'd1);
    check("read_rd1", bus.m1_rd, 32'hDEADBEEF);
    check("read_we", {31'b0, bus.mem_we}, 32'd0);
    advance();
    req[1] = 1'b0;
    cycle();

    // Master 0 writes, master 1 reads back with no idle bubble
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h12345678;
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h20;
    cycle();
    sample();
    check("wr_ack0", {31'b0, bus.m0_ack}, 32'd1);
    check("wr_we", {31'b0, bus.mem_we}, 32'd1);
    advance();
    req[0] = 1'b0; we[0] = 1'b0;
    sample();
    check("rb_ack1", {31'b0, bus.m1_ack}, 32'd1);
    check("rb_rd1", bus.m1_rd, 32'h12345678);
    advance();
    req[1] = 1'b0;
    cycle();

    // Unlocked contention alternates every beat
    req[0] = 1'b1; req[1] = 1'b1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      sample();
      check($sformatf("alt_ack0_%0d", k), {31'b0, bus.m0_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("alt_ack1_%0d", k), {31'b0, bus.m1_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
      advance();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    cycle();

    // Locked burst is cut off after MAX_BURST beats, then parks when alone
    req[0] = 1'b1; lock[0] = 1'b1;
    cycle();
    req[1] = 1'b1;
    for (int k = 0; k <= MAX_BURST; k++) begin
      sample();
      if (k < MAX_BURST) check($sformatf("burst_ack0_%0d", k), {31'b0, bus.m0_ack}, 32'd1);
      else check("burst_gnt1", {31'b0, bus.m1_gnt}, 32'd1);
      advance();
    end
    req[1] = 1'b0;
    for (int k = 0; k < MAX_BURST + 2; k++) begin
      sample();
      check($sformatf("park_ack0_%0d", k), {31'b0, bus.m0_ack}, 32'd1);
      advance();
    end

    // Abort: owner drops req with we=1
    req[0] = 1'b0; we[0] = 1'b1; lock[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0;
    sample();
    check("abort0_we", {31'b0, bus.mem_we}, 32'd0);
    advance();
    sample();
    check("abort0_gnt1", {31'b0, bus.m1_gnt}, 32'd1);
    advance();
    req[1] = 1'b0; we[1] = 1'b1; we[0] = 1'b0;
    sample();
    check("abort1_we", {31'b0, bus.mem_we}, 32'd0);
    advance();
    sample();
    check("abort1_idle", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    advance();

    // Reset during a write ack cycle: write commits, grant is lost
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; wd[1] = 32'hCAFEF00D;
    cycle();
    reset = 1'b0;
    sample();
    check("rstwr_we", {31'b0, bus.mem_we}, 32'd1);
    advance();
    reset = 1'b1; req[1] = 1'b0; we[1] = 1'b0;
    sample();
    check("rstwr_gnt1", {31'b0, bus.m1_gnt}, 32'd0);
    advance();
    req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h30;
    cycle();
    sample();
    check("rstwr_rd0", bus.m0_rd, 32'hCAFEF00D);
    advance();
    req[0] = 1'b0;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < RAND_CYCLES; n++) begin
      drive_random();
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
